// File: rtl/id_ex_stage_reg.sv
// ID->EX pipeline register with stall hold, flush bubble and write-back bypass.
// Optional bubble counter is enabled by defining ID_EX_BUBBLE_CNT_EN.
module id_ex_stage_reg #(
  parameter int XLEN   = 32,
  parameter int CTRL_W = 16,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              stall,
  input  logic              flush,
  input  logic              id_valid,
  input  logic [XLEN-1:0]   id_pc,
  input  logic [4:0]        id_rs1,
  input  logic [4:0]        id_rs2,
  input  logic [4:0]        id_rd,
  input  logic [XLEN-1:0]   id_rd1,
  input  logic [XLEN-1:0]   id_rd2,
  input  logic [XLEN-1:0]   id_imm,
  input  logic [CTRL_W-1:0] id_ctrl,
  input  logic              wb_we,
  input  logic [4:0]        wb_rd,
  input  logic [XLEN-1:0]   wb_wd,
`ifdef ID_EX_BUBBLE_CNT_EN
  output logic [CNT_W-1:0]  bubble_cnt,
`endif
  output logic              ex_valid,
  output logic [XLEN-1:0]   ex_pc,
  output logic [4:0]        ex_rs1,
  output logic [4:0]        ex_rs2,
  output logic [4:0]        ex_rd,
  output logic [XLEN-1:0]   ex_op1,
  output logic [XLEN-1:0]   ex_op2,
  output logic [XLEN-1:0]   ex_imm,
  output logic [CTRL_W-1:0] ex_ctrl
);

  logic            wb_live;
  logic            ld_hit1, ld_hit2, hold_hit1, hold_hit2;
  logic [XLEN-1:0] ld_op1, ld_op2;

  // A write to x0 never forwards anywhere, so gate it once here.
  assign wb_live   = wb_we && (wb_rd != 5'd0);
  assign ld_hit1   = wb_live && (wb_rd == id_rs1);
  assign ld_hit2   = wb_live && (wb_rd == id_rs2);
  assign hold_hit1 = wb_live && (wb_rd == ex_rs1);
  assign hold_hit2 = wb_live && (wb_rd == ex_rs2);

  always_comb begin
    ld_op1 = id_rd1;
    ld_op2 = id_rd2;
    if (ld_hit1)         ld_op1 = wb_wd;
    if (ld_hit2)         ld_op2 = wb_wd;
    if (id_rs1 == 5'd0)  ld_op1 = '0;
    if (id_rs2 == 5'd0)  ld_op2 = '0;
  end

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      ex_valid <= 1'b0;
      ex_pc    <= '0;
      ex_rs1   <= '0;
      ex_rs2   <= '0;
      ex_rd    <= '0;
      ex_op1   <= '0;
      ex_op2   <= '0;
      ex_imm   <= '0;
      ex_ctrl  <= '0;
    end else if (stall) begin
      // Held operands still track WB so EX never resumes with stale data.
      if (hold_hit1) ex_op1 <= wb_wd;
      if (hold_hit2) ex_op2 <= wb_wd;
    end else begin
      ex_valid <= id_valid;
      ex_pc    <= id_pc;
      ex_rs1   <= id_rs1;
      ex_rs2   <= id_rs2;
      ex_rd    <= id_rd;
      ex_op1   <= ld_op1;
      ex_op2   <= ld_op2;
      ex_imm   <= id_imm;
      ex_ctrl  <= id_valid ? id_ctrl : '0;
    end
  end

`ifdef ID_EX_BUBBLE_CNT_EN
  always_ff @(posedge clk) begin
    if (rst)
      bubble_cnt <= '0;
    else if (flush || (!stall && !id_valid))
      bubble_cnt <= bubble_cnt + 1'b1;
  end
`endif

endmodule

// File: tb/tb_id_ex_stage_reg.sv
// Scoreboard bench for id_ex_stage_reg: driver queues hand-computed expectations,
// monitor pops one per clock edge and compares.
module tb_id_ex_stage_reg;

`ifdef ID_EX_BUBBLE_CNT_EN
  localparam int CW = 4;
`else
  localparam int CW = 16;
`endif

  typedef struct {
    logic        rst, stall, flush, valid;
    logic [31:0] pc;
    logic [4:0]  rs1, rs2, rd;
    logic [31:0] rd1, rd2, imm;
    logic [15:0] ctrl;
    logic        we;
    logic [4:0]  wrd;
    logic [31:0] wd;
  } in_t;

  typedef struct {
    string       name;
    logic        valid;
    logic [31:0] pc;
    logic [4:0]  rs1, rs2, rd;
    logic [31:0] op1, op2, imm;
    logic [15:0] ctrl;
    int          cnt;
  } exp_t;

  logic clk = 1'b0;
  logic rst, stall, flush, id_valid, wb_we;
  logic [31:0] id_pc, id_rd1, id_rd2, id_imm, wb_wd;
  logic [4:0]  id_rs1, id_rs2, id_rd, wb_rd;
  logic [15:0] id_ctrl;
  logic        ex_valid;
  logic [31:0] ex_pc, ex_op1, ex_op2, ex_imm;
  logic [4:0]  ex_rs1, ex_rs2, ex_rd;
  logic [15:0] ex_ctrl;
`ifdef ID_EX_BUBBLE_CNT_EN
  logic [CW-1:0] bubble_cnt;
`endif

  int tests = 0, fails = 0;
  exp_t sb[$];

  always #5 clk = ~clk;

  id_ex_stage_reg #(.XLEN(32), .CTRL_W(16), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst), .stall(stall), .flush(flush), .id_valid(id_valid),
    .id_pc(id_pc), .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd),
    .id_rd1(id_rd1), .id_rd2(id_rd2), .id_imm(id_imm), .id_ctrl(id_ctrl),
    .wb_we(wb_we), .wb_rd(wb_rd), .wb_wd(wb_wd),
`ifdef ID_EX_BUBBLE_CNT_EN
    .bubble_cnt(bubble_cnt),
`endif
    .ex_valid(ex_valid), .ex_pc(ex_pc), .ex_rs1(ex_rs1), .ex_rs2(ex_rs2),
    .ex_rd(ex_rd), .ex_op1(ex_op1), .ex_op2(ex_op2), .ex_imm(ex_imm),
    .ex_ctrl(ex_ctrl)
  );

  function automatic in_t vi(logic r, logic s, logic f, logic v, logic [31:0] pc,
                             logic [4:0] rs1, logic [4:0] rs2, logic [4:0] rd,
                             logic [31:0] rd1, logic [31:0] rd2, logic [31:0] imm,
                             logic [15:0] ctrl, logic we, logic [4:0] wrd, logic [31:0] wd);
    in_t i;
    i.rst = r; i.stall = s; i.flush = f; i.valid = v; i.pc = pc;
    i.rs1 = rs1; i.rs2 = rs2; i.rd = rd; i.rd1 = rd1; i.rd2 = rd2; i.imm = imm;
    i.ctrl = ctrl; i.we = we; i.wrd = wrd; i.wd = wd;
    return i;
  endfunction

  function automatic exp_t ve(string n, logic v, logic [31:0] pc, logic [4:0] rs1,
                              logic [4:0] rs2, logic [4:0] rd, logic [31:0] op1,
                              logic [31:0] op2, logic [31:0] imm, logic [15:0] ctrl, int cnt);
    exp_t e;
    e.name = n; e.valid = v; e.pc = pc; e.rs1 = rs1; e.rs2 = rs2; e.rd = rd;
    e.op1 = op1; e.op2 = op2; e.imm = imm; e.ctrl = ctrl; e.cnt = cnt;
    return e;
  endfunction

  task automatic drive(input in_t i, input exp_t e);
    @(negedge clk);
    rst = i.rst; stall = i.stall; flush = i.flush; id_valid = i.valid;
    id_pc = i.pc; id_rs1 = i.rs1; id_rs2 = i.rs2; id_rd = i.rd;
    id_rd1 = i.rd1; id_rd2 = i.rd2; id_imm = i.imm; id_ctrl = i.ctrl;
    wb_we = i.we; wb_rd = i.wrd; wb_wd = i.wd;
    sb.push_back(e);
  endtask

  // Monitor: every edge following a drive produces exactly one observation.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (sb.size() > 0) begin
        exp_t e;
        int   act_cnt, exp_cnt;
        e = sb.pop_front();
`ifdef ID_EX_BUBBLE_CNT_EN
        act_cnt = int'(bubble_cnt);
        exp_cnt = e.cnt % (1 << CW);
`else
        act_cnt = 0;
        exp_cnt = 0;
`endif
        tests++;
        if (ex_valid !== e.valid || ex_pc !== e.pc || ex_rs1 !== e.rs1 ||
            ex_rs2 !== e.rs2 || ex_rd !== e.rd || ex_op1 !== e.op1 ||
            ex_op2 !== e.op2 || ex_imm !== e.imm || ex_ctrl !== e.ctrl ||
            act_cnt != exp_cnt) begin
          fails++;
          $display("FAIL %s: got v=%0b pc=%h rs1=%0d rs2=%0d rd=%0d op1=%h op2=%h imm=%h ctrl=%h cnt=%0d | want v=%0b pc=%h rs1=%0d rs2=%0d rd=%0d op1=%h op2=%h imm=%h ctrl=%h cnt=%0d",
                   e.name, ex_valid, ex_pc, ex_rs1, ex_rs2, ex_rd, ex_op1, ex_op2, ex_imm, ex_ctrl, act_cnt,
                   e.valid, e.pc, e.rs1, e.rs2, e.rd, e.op1, e.op2, e.imm, e.ctrl, exp_cnt);
        end
      end
    end
  end

  initial begin
    rst = 1'b1; stall = 1'b0; flush = 1'b0; id_valid = 1'b0; id_pc = '0;
    id_rs1 = '0; id_rs2 = '0; id_rd = '0; id_rd1 = '0; id_rd2 = '0; id_imm = '0;
    id_ctrl = '0; wb_we = 1'b0; wb_rd = '0; wb_wd = '0;

    // Reset with busy ID inputs, then reset while stall+flush are high.
    drive(vi(1,0,0,1,32'h100,5'd1,5'd2,5'd3,32'h5,32'h6,32'h7,16'hFFFF,1,5'd1,32'h9),
          ve("reset1",0,0,0,0,0,0,0,0,0,0));
    drive(vi(1,1,1,1,32'h100,5'd1,5'd2,5'd3,32'h5,32'h6,32'h7,16'hFFFF,1,5'd1,32'h9),
          ve("reset2",0,0,0,0,0,0,0,0,0,0));
    drive(vi(0,0,0,1,32'h40,5'd5,5'd6,5'd3,32'h11,32'h22,32'hFFFFFFF0,16'h00A5,0,5'd0,32'h0),
          ve("plain_load",1,32'h40,5,6,3,32'h11,32'h22,32'hFFFFFFF0,16'h00A5,0));
    drive(vi(0,0,0,1,32'h44,5'd7,5'd6,5'd4,32'hAAAA,32'h22,32'h4,16'h0003,1,5'd7,32'h1234),
          ve("bypass_op1",1,32'h44,7,6,4,32'h1234,32'h22,32'h4,16'h0003,0));
    drive(vi(0,0,0,1,32'h48,5'd0,5'd8,5'd5,32'hBBBB,32'h99,32'h8,16'h0007,1,5'd0,32'h5555),
          ve("bypass_x0",1,32'h48,0,8,5,32'h0,32'h99,32'h8,16'h0007,0));
    drive(vi(0,0,0,1,32'h4C,5'd1,5'd2,5'd6,32'h10,32'h20,32'h0,16'h0001,1,5'd2,32'hCAFE),
          ve("bypass_op2",1,32'h4C,1,2,6,32'h10,32'hCAFE,32'h0,16'h0001,0));
    drive(vi(0,0,0,1,32'h50,5'd2,5'd2,5'd7,32'h31,32'h32,32'h0,16'h0002,0,5'd2,32'hDEAD),
          ve("no_we_no_bypass",1,32'h50,2,2,7,32'h31,32'h32,32'h0,16'h0002,0));
    drive(vi(0,0,0,0,32'h54,5'd3,5'd4,5'd8,32'h41,32'h42,32'hC,16'hFFFF,0,5'd0,32'h0),
          ve("invalid_load",0,32'h54,3,4,8,32'h41,32'h42,32'hC,16'h0000,1));
    drive(vi(0,0,0,1,32'h60,5'd10,5'd9,5'd11,32'h3,32'h5,32'h10,16'h0042,0,5'd0,32'h0),
          ve("load_before_stall",1,32'h60,10,9,11,32'h3,32'h5,32'h10,16'h0042,1));
    // Stall window: ID inputs change but must be ignored.
    drive(vi(0,1,0,0,32'h999,5'd1,5'd1,5'd1,32'hEE,32'hEE,32'hEE,16'h1111,1,5'd0,32'h88),
          ve("stall_c1_x0_write",1,32'h60,10,9,11,32'h3,32'h5,32'h10,16'h0042,1));
    drive(vi(0,1,0,0,32'h999,5'd1,5'd1,5'd1,32'hEE,32'hEE,32'hEE,16'h1111,1,5'd9,32'h77),
          ve("stall_c2_update",1,32'h60,10,9,11,32'h3,32'h77,32'h10,16'h0042,1));
    drive(vi(0,1,0,1,32'h999,5'd1,5'd1,5'd1,32'hEE,32'hEE,32'hEE,16'h1111,0,5'd10,32'h55),
          ve("stall_c3_hold",1,32'h60,10,9,11,32'h3,32'h77,32'h10,16'h0042,1));
    drive(vi(0,1,0,1,32'h999,5'd1,5'd1,5'd1,32'hEE,32'hEE,32'hEE,16'h1111,1,5'd10,32'h66),
          ve("stall_op1_update",1,32'h60,10,9,11,32'h66,32'h77,32'h10,16'h0042,1));
    drive(vi(0,1,1,1,32'h999,5'd1,5'd1,5'd1,32'hEE,32'hEE,32'hEE,16'h1111,1,5'd10,32'h66),
          ve("flush_over_stall",0,0,0,0,0,0,0,0,0,2));
    drive(vi(0,0,0,1,32'h80,5'd12,5'd13,5'd14,32'h100,32'h200,32'h20,16'h0F0F,0,5'd0,32'h0),
          ve("load_after_flush",1,32'h80,12,13,14,32'h100,32'h200,32'h20,16'h0F0F,2));
    drive(vi(0,0,1,1,32'h84,5'd12,5'd13,5'd14,32'h100,32'h200,32'h20,16'h0F0F,0,5'd0,32'h0),
          ve("flush_only",0,0,0,0,0,0,0,0,0,3));
    drive(vi(1,0,1,1,32'h84,5'd12,5'd13,5'd14,32'h100,32'h200,32'h20,16'h0F0F,0,5'd0,32'h0),
          ve("reset_over_flush",0,0,0,0,0,0,0,0,0,0));
    // 17 flushes from reset: counter walks 1..15, 0, 1.
    for (int k = 1; k <= 17; k++)
      drive(vi(0,0,1,1,32'hC0,5'd1,5'd2,5'd3,32'h1,32'h2,32'h3,16'h00FF,0,5'd0,32'h0),
            ve("flush_run",0,0,0,0,0,0,0,0,0,k));

    for (int w = 0; w < 10 && sb.size() > 0; w++) @(negedge clk);
    if (sb.size() > 0) begin
      fails++;
      $display("FAIL drain: %0d expected results never observed, want 0", sb.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/id_ex_stage_reg.md
Name: id_ex_stage_reg

Overview:
- Decode-to-execute pipeline register in the pipelined RISC-V core.
- Captures the two register-file read operands plus decode fields at the end of ID, and presents them to EX one cycle later.
- Supports stall (hold), flush (bubble insertion) and write-back bypass, so EX never sees a stale operand when WB writes the same register in the same cycle or during a stall.

Parameters:
- XLEN, 32, datapath width of PC, operands and immediate.
- CTRL_W, 16, width of the opaque decoded control bundle passed to EX.
- CNT_W, 16, width of the bubble counter (optional feature only).

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous active-high reset.
- stall  in  1  hold all EX-side outputs (from hazard unit).
- flush  in  1  replace the next EX contents with a bubble (branch/jump redirect).
- id_valid  in  1  ID holds a real instruction.
- id_pc  in  XLEN  PC of the ID instruction.
- id_rs1  in  5  source register 1 index (register file A1).
- id_rs2  in  5  source register 2 index (register file A2).
- id_rd  in  5  destination register index.
- id_rd1  in  XLEN  register file RD1.
- id_rd2  in  XLEN  register file RD2.
- id_imm  in  XLEN  sign-extended immediate.
- id_ctrl  in  CTRL_W  decoded control bundle.
- wb_we  in  1  WB write enable (same signal as register file WE3).
- wb_rd  in  5  WB destination (register file A3).
- wb_wd  in  XLEN  WB data (register file WD3).
- ex_valid  out  1  EX slot holds a real instruction.
- ex_pc  out  XLEN  registered PC.
- ex_rs1  out  5  registered rs1.
- ex_rs2  out  5  registered rs2.
- ex_rd  out  5  registered rd.
- ex_op1  out  XLEN  registered operand 1.
- ex_op2  out  XLEN  registered operand 2.
- ex_imm  out  XLEN  registered immediate.
- ex_ctrl  out  CTRL_W  registered control bundle.
- bubble_cnt  out  CNT_W  bubbles inserted (present only with the optional feature).

Behaviour:
- All outputs are registered and update on the rising clk edge only. Latency is one cycle from ID to EX.
- Per-edge priority: rst > flush > stall > load.
- rst: every output goes to 0, including ex_valid=0 and ex_ctrl=0. This applies regardless of stall or flush.
- flush (stall may also be high): ex_valid=0, ex_ctrl=0, ex_rd=0. Other fields go to 0. Flush overrides stall.
- stall (no flush): every field holds its value, with one exception, the hold-update rule:
  - if wb_we=1, wb_rd!=0 and wb_rd==ex_rs1, ex_op1 takes wb_wd.
  - the same rule applies to ex_rs2 and ex_op2.
  - ex_valid holds.
- load: all fields take the id_* values, and ex_valid takes id_valid. Operand selection:
  - op1 = wb_wd if wb_we=1, wb_rd!=0 and wb_rd==id_rs1; otherwise id_rd1.
  - op2 is selected the same way using id_rs2 and id_rd2.
  - This bypass covers a register file write and read in the same cycle.
- x0: if id_rs1==0, op1 is forced to 0 regardless of id_rd1 or any WB write to x0. The same applies to rs2/op2. A WB write with wb_rd=0 never updates a held operand.
- A load with id_valid=0 still captures the fields, but ex_valid=0 and ex_ctrl is forced to 0 so EX has no side effects.
- No combinational path from any input to any output.

Optional Feature:
- Macro: ID_EX_BUBBLE_CNT_EN.
- Defined: adds the bubble_cnt port, a CNT_W-bit counter.
  - Reset to 0 by rst.
  - +1 on every edge where flush=1, or where stall=0 and id_valid=0.
  - Wraps from all-ones to 0.
  - Stalled cycles do not count.
- Undefined: no bubble_cnt port and no counter logic. All other behaviour is identical.

Test Plan:
- Reset: rst=1 for 2 cycles with id_* nonzero (id_pc=0x100, id_ctrl=0xFFFF) -> all ex_* = 0, ex_valid=0.
- Plain load: id_valid=1, id_pc=0x40, rs1=5, rs2=6, id_rd1=0x11, id_rd2=0x22, id_imm=0xFFFFFFF0, wb_we=0 -> next cycle ex_pc=0x40, ex_op1=0x11, ex_op2=0x22, ex_imm=0xFFFFFFF0, ex_valid=1.
- Same-cycle bypass: id_rs1=7, id_rd1=0xAAAA, wb_we=1, wb_rd=7, wb_wd=0x1234 -> ex_op1=0x1234. Repeat with rs1=0, wb_rd=0 -> ex_op1=0.
- Stall with hold-update: load rs2=9, op2=0x5; then stall=1 for 3 cycles, with wb_we=1, wb_rd=9, wb_wd=0x77 in cycle 2 -> ex_op2=0x5 until the update, then 0x77. Other fields and ex_valid stay constant.
- Flush vs stall: stall=1 and flush=1 together while ex_valid=1 -> next cycle ex_valid=0, ex_ctrl=0, ex_rd=0. With the macro defined, bubble_cnt increments by 1.
- Counter wrap (macro defined, CNT_W=4): 17 consecutive flushes from reset -> bubble_cnt reads 1.
